// File: rtl/alu_cmd_stage.sv
// Wishbone-fed ALU command queue: commands are issued one at a time to the ALU port and results queued for readback.
// Latency: a CMD ack is followed by a queued result 3 cycles later, with irq_o one cycle after that.
// Backpressure: the FSM stalls while the result FIFO is full; CMD writes into a full command FIFO are dropped and flagged.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          core_clk,
    input  logic          arst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_vld & ~empty;
    assign head_dat = mem[rd_ptr];

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module alu_cmd_stage #(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DW         = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [1:0]    alu_sel_o,
    input  logic [DW-1:0] alu_out_i,
    input  logic          alu_carry_i,
    output logic          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 2*DW + 2;
    localparam int RW = DW + 1;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] b;
        logic [DW-1:0] a;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic          req, wr_req, rd_req, wr_full_sel;
    logic [1:0]    offset;
    logic          cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic          res_push, res_pop, res_full, res_empty;
    cmd_t          cmd_head;
    logic [RW-1:0] res_head;
    logic [AW:0]   cmd_cnt, res_cnt;
    logic          stat_wr, ovf, unf, ovf_set, unf_set;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign req         = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign wr_req      = req & wbs_we_i;
    assign rd_req      = req & ~wbs_we_i;
    assign wr_full_sel = (wbs_sel_i == 4'hF);
    assign offset      = wbs_adr_i[3:2];

    assign cmd_push = wr_req & wr_full_sel & (offset == 2'd0);
    assign ovf_set  = cmd_push & cmd_full;
    assign res_pop  = rd_req & (offset == 2'd1);
    assign unf_set  = res_pop & res_empty;
    assign stat_wr  = wr_req & wr_full_sel & (offset == 2'd2);

    assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:CW]};

    sync_fifo #(.DEPTH(FIFO_DEPTH), .W(CW)) u_cmd_fifo (
        .core_clk (wb_clk_i),
        .arst_n   (wb_rst_ni),
        .push_vld (cmd_push),
        .push_dat (wbs_dat_i[CW-1:0]),
        .pop_vld  (cmd_pop),
        .head_dat (cmd_head),
        .cnt      (cmd_cnt),
        .full     (cmd_full),
        .empty    (cmd_empty)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .W(RW)) u_res_fifo (
        .core_clk (wb_clk_i),
        .arst_n   (wb_rst_ni),
        .push_vld (res_push),
        .push_dat ({alu_carry_i, alu_out_i}),
        .pop_vld  (res_pop),
        .head_dat (res_head),
        .cnt      (res_cnt),
        .full     (res_full),
        .empty    (res_empty)
    );

    // Only one command is ever in flight, so checking for a free result slot at issue is enough.
    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        res_push  = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !res_full) begin
                    cmd_pop   = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE:   state_nxt = CAPTURE;
            CAPTURE: begin
                res_push  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'b0;
        case (offset)
            2'd1: if (!res_empty) rdata = 32'(res_head);
            2'd2: begin
                rdata[3:0] = 4'(cmd_cnt);
                rdata[7:4] = 4'(res_cnt);
                rdata[8]   = ovf;
                rdata[9]   = unf;
                rdata[10]  = (state != IDLE);
            end
            default: rdata = 32'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'b0;
            alu_a_o   <= '0;
            alu_b_o   <= '0;
            alu_sel_o <= 2'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wbs_ack_o <= req;
            wbs_dat_o <= rd_req ? rdata : 32'b0;
            if (cmd_pop) begin
                alu_a_o   <= cmd_head.a;
                alu_b_o   <= cmd_head.b;
                alu_sel_o <= cmd_head.sel;
            end
            // A set in the same cycle as a clear takes priority.
            ovf   <= (ovf & ~(stat_wr & wbs_dat_i[8])) | ovf_set;
            unf   <= (unf & ~(stat_wr & wbs_dat_i[9])) | unf_set;
            irq_o <= (res_cnt != '0);
        end
    end
endmodule

// File: tb/tb_alu_cmd_stage.sv
module tb_alu_cmd_stage;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [1:0]  alu_sel;
    logic        alu_carry;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [17:0] cmd_q[$];
    logic [8:0]  res_q[$];
    bit          m_ovf, m_unf;

    always #5 clk = ~clk;

    alu_cmd_stage dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_sel_o   (alu_sel),
        .alu_out_i   (alu_out),
        .alu_carry_i (alu_carry),
        .irq_o       (irq)
    );

    // Stand-in for the ALU macro: add, subtract (borrow in carry), and, xor.
    always_comb begin
        case (alu_sel)
            2'd0:    {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1:    {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            2'd2:    {alu_carry, alu_out} = {1'b0, alu_a & alu_b};
            default: {alu_carry, alu_out} = {1'b0, alu_a ^ alu_b};
        endcase
    end

    function automatic logic [8:0] ref_alu(logic [17:0] c);
        int a, b, r;
        a = int'(c[7:0]);
        b = int'(c[15:8]);
        case (c[17:16])
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return 9'(r);
    endfunction

    function automatic logic [31:0] exp_status();
        return {21'b0, 1'b0, m_unf, m_ovf, 4'(res_q.size()), 4'(cmd_q.size())};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        logic [17:0] c;
        while (cmd_q.size() > 0 && res_q.size() < DEPTH) begin
            c = cmd_q.pop_front();
            res_q.push_back(ref_alu(c));
        end
    endtask

    task automatic post_op();
        repeat (5) @(posedge clk);
        #1;
        settle();
        chk("irq", 32'(irq), 32'(res_q.size() != 0));
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat, output logic acked);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        acked = 1'b0;
        rdat  = 32'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1'b1;
                rdat  = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic cmd_wr(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [3:0] s);
        logic [31:0] r;
        logic        k;
        xfer(1'b1, BASE, {14'b0, op, b, a}, s, r, k);
        chk("cmd_ack", 32'(k), 32'd1);
        if (s == 4'hF) begin
            if (cmd_q.size() == DEPTH) m_ovf = 1'b1;
            else cmd_q.push_back({op, b, a});
        end
        post_op();
    endtask

    task automatic res_rd();
        logic [31:0] r, e;
        logic        k;
        xfer(1'b0, BASE + 32'h4, 32'b0, 4'hF, r, k);
        chk("res_ack", 32'(k), 32'd1);
        if (res_q.size() == 0) begin
            e = 32'b0;
            m_unf = 1'b1;
        end else begin
            e = 32'(res_q.pop_front());
        end
        chk("res_data", r, e);
        post_op();
    endtask

    task automatic stat_rd(string tag);
        logic [31:0] r;
        logic        k;
        xfer(1'b0, BASE + 32'h8, 32'b0, 4'hF, r, k);
        chk("stat_ack", 32'(k), 32'd1);
        chk(tag, r, exp_status());
        post_op();
    endtask

    task automatic stat_wr(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic        k;
        xfer(1'b1, BASE + 32'h8, d, s, r, k);
        chk("statw_ack", 32'(k), 32'd1);
        if (s == 4'hF) begin
            if (d[8]) m_ovf = 1'b0;
            if (d[9]) m_unf = 1'b0;
        end
        post_op();
    endtask

    task automatic other_rd(input logic [1:0] off);
        logic [31:0] r;
        logic        k;
        xfer(1'b0, BASE + {28'b0, off, 2'b0}, 32'b0, 4'hF, r, k);
        chk("other_ack", 32'(k), 32'd1);
        chk("other_rdata", r, 32'b0);
        post_op();
    endtask

    task automatic other_wr(input logic [1:0] off, input logic [31:0] d);
        logic [31:0] r;
        logic        k;
        xfer(1'b1, BASE + {28'b0, off, 2'b0}, d, 4'hF, r, k);
        chk("otherw_ack", 32'(k), 32'd1);
        post_op();
    endtask

    initial begin
        logic [31:0] r;
        logic        k;
        int          op;

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; dat_i = 32'b0; adr = 32'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_alu", {14'b0, alu_sel, alu_b, alu_a}, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First command with exact issue and result latency.
        xfer(1'b1, BASE, 32'h0000_3412, 4'hF, r, k);
        chk("t1_ack", 32'(k), 32'd1);
        chk("t1_a_before_issue", 32'(alu_a), 32'h00);
        @(posedge clk); #1;
        chk("t1_a_drive", 32'(alu_a), 32'h12);
        chk("t1_b_drive", 32'(alu_b), 32'h34);
        chk("t1_sel_drive", 32'(alu_sel), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_irq_early", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("t1_irq_4cyc", 32'(irq), 32'd1);
        chk("t1_a_hold", 32'(alu_a), 32'h12);
        cmd_q.push_back(18'h03412);
        post_op();
        stat_rd("t1_status");
        res_rd();

        cmd_wr(8'hFF, 8'h01, 2'd0, 4'hF);
        res_rd();

        // Result FIFO fills; the fifth command waits.
        for (int i = 0; i < 5; i++) cmd_wr(8'(i * 37 + 5), 8'(i * 11 + 200), 2'(i), 4'hF);
        stat_rd("five_cmds");
        res_rd();
        stat_rd("after_one_pop");

        // FSM stalled: command FIFO fills and the fifth write overflows.
        for (int i = 0; i < 5; i++) cmd_wr(8'(i + 1), 8'(i + 3), 2'd1, 4'hF);
        stat_rd("overflow");
        stat_wr(32'h100, 4'hF);
        stat_rd("ovf_cleared");

        for (int i = 0; i < 9; i++) res_rd();
        stat_rd("underflow");
        stat_wr(32'h200, 4'hF);
        stat_rd("unf_cleared");

        other_rd(2'd0);
        other_rd(2'd3);
        other_wr(2'd1, 32'hFFFF_FFFF);
        other_wr(2'd3, 32'hFFFF_FFFF);
        cmd_wr(8'h55, 8'hAA, 2'd3, 4'h7);
        stat_rd("ignored_writes");

        xfer(1'b0, BASE + 32'h10, 32'b0, 4'hF, r, k);
        chk("miss_low_window", 32'(k), 32'd0);
        xfer(1'b1, 32'h2000_0000, 32'h0000_0102, 4'hF, r, k);
        chk("miss_other_base", 32'(k), 32'd0);
        post_op();
        stat_rd("after_miss");

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            if (op < 4)       cmd_wr(8'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hF);
            else if (op < 7)  res_rd();
            else if (op == 7) stat_rd("rnd_status");
            else if (op == 8) stat_wr({22'b0, 2'($urandom), 8'b0}, 4'hF);
            else              other_rd(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
        end
        stat_rd("rnd_final");

        // Reset during DRIVE with results already queued.
        for (int i = 0; i < 10; i++) if (res_q.size() > 0) res_rd();
        cmd_wr(8'h21, 8'h43, 2'd0, 4'hF);
        cmd_wr(8'h65, 8'h07, 2'd2, 4'hF);
        xfer(1'b1, BASE, 32'h0000_9988, 4'hF, r, k);
        chk("rst_mid_ack", 32'(k), 32'd1);
        @(posedge clk); #1;
        chk("rst_mid_drive_a", 32'(alu_a), 32'h88);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_alu", {14'b0, alu_sel, alu_b, alu_a}, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        chk("rst_mid_ack_low", 32'(ack), 32'd0);
        chk("rst_mid_dat", dat_o, 32'd0);
        cmd_q.delete();
        res_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        post_op();
        stat_rd("rst_mid_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
